// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one RV32I load/store in flight at a time,
// answered after a fixed latency over a word-organised little-endian array.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are
  // both 1; req_ready is high only in IDLE, so at most one access is ever outstanding.
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     cur_word;
  logic [31:0]     lane_shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_data;
  logic [31:0]     store_word;
  logic            acc_err;
  logic            do_access;
  logic            mem_we;
  logic            unused_addr_hi;

  // Bits above the array size only wrap the address and are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign idx          = addr_q[AW+1:2];
  assign lane         = addr_q[1:0];
  assign cur_word     = mem[idx];
  assign lane_shifted = cur_word >> {lane, 3'b000};
  assign byte_sel     = lane_shifted[7:0];
  assign half_sel     = lane[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    acc_err = 1'b0;
    if (we_q) begin
      acc_err = (funct3_q > 3'd2);
    end else begin
      acc_err = (funct3_q == 3'd3) || (funct3_q[2:1] == 2'b11);
    end
    if (funct3_q[1:0] == 2'b01 && lane[0]) acc_err = 1'b1;
    if (funct3_q[1:0] == 2'b10 && lane != 2'b00) acc_err = 1'b1;
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3_q)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = cur_word;
      3'd4:    load_data = {24'h0, byte_sel};
      3'd5:    load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the current word contents.
  always_comb begin
    store_word = cur_word;
    case (funct3_q[1:0])
      2'b00: store_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane[1]) store_word[31:16] = wdata_q[15:0];
        else         store_word[15:0]  = wdata_q[15:0];
      end
      2'b10:   store_word = wdata_q;
      default: store_word = cur_word;
    endcase
  end

  assign do_access = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we    = do_access && we_q && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= store_word;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[AW+1:0];
          wdata_d  = req_wdata;
          cnt_d    = CW'(LATENCY - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_err_d   = acc_err;
          rsp_rdata_d = (we_q || acc_err) ? 32'h0 : load_data;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'h0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
